boss_projectile_engine: RTL

- Consumer of the boss attack interface.
- On each one-cycle bossShoot pulse, latches a volley of up to five spawn points, the shared size and the attack type.
- Advances the volley once per game frame, retires projectiles that leave the play field, and reports player collisions to the player/HP logic.
- Feeds per-slot positions to the VGA renderer.

---
 rtl/boss_projectile_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/boss_projectile_engine.sv
// rtl/boss_projectile_engine.sv - boss volley engine: load, frame step, retire, player collision
module boss_projectile_engine #(
  parameter int PROJ_SPEED = 4,
  parameter int DIAG_DX    = 3,
  parameter int BEAM_LIFE  = 45,
  parameter int LEFT_X     = 144,
  parameter int RIGHT_X    = 784,
  parameter int BOTTOM_Y   = 511
) (
  input  logic        clk_master,
  input  logic        rst,
  input  logic        pulse_frame,
  input  logic        bossShoot,
  input  logic [1:0]  attackType,
  input  logic [9:0]  proj1X,
  input  logic [9:0]  proj2X,
  input  logic [9:0]  proj3X,
  input  logic [9:0]  proj4X,
  input  logic [9:0]  proj5X,
  input  logic [8:0]  proj1Y,
  input  logic [8:0]  proj2Y,
  input  logic [8:0]  proj3Y,
  input  logic [8:0]  proj4Y,
  input  logic [8:0]  proj5Y,
  input  logic [9:0]  projW,
  input  logic [8:0]  projH,
  input  logic [9:0]  playerX,
  input  logic [8:0]  playerY,
  input  logic [9:0]  playerW,
  input  logic [8:0]  playerH,
  output logic [4:0]  projActive,
  output logic [49:0] projXBus,
  output logic [44:0] projYBus,
  output logic [9:0]  projWOut,
  output logic [8:0]  projHOut,
  output logic [1:0]  projType,
  output logic        playerHit
);

  localparam logic [1:0] ATK_BEAM = 2'b01;
  localparam logic [1:0] ATK_DIAG = 2'b10;
  localparam logic [1:0] ATK_NONE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FLYING, S_BEAM} state_t;

  state_t           state_q, state_d;
  logic [4:0][9:0]  x_q, x_d, spawn_x;
  logic [4:0][8:0]  y_q, y_d, spawn_y;
  logic [4:0]       act_q, act_d, overlap, retire;
  logic [9:0]       w_q, w_d;
  logic [8:0]       h_q, h_d;
  logic [1:0]       type_q, type_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             done_q, done_d, hit_q, hit_d;

  assign spawn_x = {proj5X, proj4X, proj3X, proj2X, proj1X};
  assign spawn_y = {proj5Y, proj4Y, proj3Y, proj2Y, proj1Y};

  // All geometry is evaluated at 11 bits so sums of 10-bit operands never wrap.
  always_comb begin
    overlap = '0;
    retire  = '0;
    for (int i = 0; i < 5; i++) begin
      overlap[i] = ({1'b0, x_q[i]} < ({1'b0, playerX} + {1'b0, playerW})) &&
                   ({1'b0, playerX} < ({1'b0, x_q[i]} + {1'b0, w_q})) &&
                   ({2'b0, y_q[i]} < ({2'b0, playerY} + {2'b0, playerH})) &&
                   ({2'b0, playerY} < ({2'b0, y_q[i]} + {2'b0, h_q}));
      retire[i]  = ({2'b0, y_q[i]} + 11'(PROJ_SPEED) + {2'b0, h_q}) > 11'(BOTTOM_Y);
    end
    if (type_q == ATK_DIAG) begin
      if ({1'b0, x_q[0]} < 11'(LEFT_X + DIAG_DX))
        retire[0] = 1'b1;
      if (({1'b0, x_q[1]} + 11'(DIAG_DX) + {1'b0, w_q}) > 11'(RIGHT_X))
        retire[1] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    w_d     = w_q;
    h_d     = h_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    hit_d   = 1'b0;
    if (bossShoot) begin
      if (attackType != ATK_NONE) begin
        for (int i = 0; i < 5; i++) begin
          x_d[i]   = spawn_x[i];
          y_d[i]   = spawn_y[i];
          act_d[i] = (spawn_x[i] != '0) || (spawn_y[i] != '0);
        end
        w_d     = projW;
        h_d     = projH;
        type_d  = attackType;
        cnt_d   = '0;
        done_d  = 1'b0;
        state_d = (act_d == '0) ? S_IDLE : ((attackType == ATK_BEAM) ? S_BEAM : S_FLYING);
      end
    end else if (pulse_frame) begin
      case (state_q)
        S_FLYING: begin
          for (int i = 0; i < 5; i++) begin
            if (act_q[i]) begin
              if (overlap[i]) begin
                act_d[i] = 1'b0;
                hit_d    = 1'b1;
              end else if (retire[i]) begin
                act_d[i] = 1'b0;
              end else begin
                y_d[i] = y_q[i] + 9'(PROJ_SPEED);
                if (type_q == ATK_DIAG && i == 0) x_d[i] = x_q[i] - 10'(DIAG_DX);
                if (type_q == ATK_DIAG && i == 1) x_d[i] = x_q[i] + 10'(DIAG_DX);
              end
            end
          end
        end
        S_BEAM: begin
          if (!done_q && ((overlap & act_q) != '0)) begin
            hit_d  = 1'b1;
            done_d = 1'b1;
          end
          // Compare before incrementing so the beam stays lit for BEAM_LIFE frames.
          if (cnt_q == 6'(BEAM_LIFE - 1))
            act_d = '0;
          else
            cnt_d = cnt_q + 6'd1;
        end
        default: ;
      endcase
      if (act_d == '0)
        state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      type_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      w_q     <= w_d;
      h_q     <= h_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
    end
  end

  assign projActive = act_q;
  assign projXBus   = x_q;
  assign projYBus   = y_q;
  assign projWOut   = w_q;
  assign projHOut   = h_q;
  assign projType   = type_q;
  assign playerHit  = hit_q;

endmodule
